// File: rtl/vid_stream_pkg.sv
// Shared definitions for the clocked-video stream control-packet parser.
// Packet type codes, parser states and the control-packet nibble count.
package vid_stream_pkg;

    localparam logic [3:0]  PKT_VIDEO    = 4'h0;
    localparam logic [3:0]  PKT_CTRL     = 4'hF;
    localparam int unsigned CTRL_NIBBLES = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CTRL  = 2'd1,
        VIDEO = 2'd2,
        ANC   = 2'd3
    } state_e;

    // Pixel counter increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/vid_stream_ctrl_decode.sv
// Control-packet nibble assembler: gathers width/height/interlace nibbles
// from payload beats and flags a commit when a complete packet ends.
module vid_stream_ctrl_decode
    import vid_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned BPS        = 10,
    parameter int unsigned CPP        = 2
) (
    input  logic                  rst,
    input  logic                  is_clk,
    input  logic [DATA_WIDTH-1:0] beat,
    input  logic [4:0]            nib_idx,
    input  logic                  strobe,
    input  logic                  eop,
    output logic [15:0]           width,
    output logic [15:0]           height,
    output logic [3:0]            interlace,
    output logic                  commit
);

    logic [15:0] width_q;
    logic [15:0] height_q;
    logic [3:0]  interlace_q;

    // Outputs include the current beat so the eop beat's nibbles reach the commit
    always_comb begin
        width     = width_q;
        height    = height_q;
        interlace = interlace_q;
        if (strobe) begin
            for (int unsigned k = 0; k < CPP; k++) begin
                case (5'(nib_idx + 5'(k)))
                    5'd0:    width[15:12]  = beat[BPS*k +: 4];
                    5'd1:    width[11:8]   = beat[BPS*k +: 4];
                    5'd2:    width[7:4]    = beat[BPS*k +: 4];
                    5'd3:    width[3:0]    = beat[BPS*k +: 4];
                    5'd4:    height[15:12] = beat[BPS*k +: 4];
                    5'd5:    height[11:8]  = beat[BPS*k +: 4];
                    5'd6:    height[7:4]   = beat[BPS*k +: 4];
                    5'd7:    height[3:0]   = beat[BPS*k +: 4];
                    5'd8:    interlace     = beat[BPS*k +: 4];
                    default: ;
                endcase
            end
        end
    end

    assign commit = strobe & eop &
                    ((6'(nib_idx) + 6'(CPP)) >= 6'(CTRL_NIBBLES));

    always_ff @(posedge is_clk or posedge rst) begin
        if (rst) begin
            width_q     <= '0;
            height_q    <= '0;
            interlace_q <= '0;
        end else if (strobe) begin
            width_q     <= width;
            height_q    <= height;
            interlace_q <= interlace;
        end
    end

endmodule

// File: rtl/vid_stream_ctrl_parser.sv
// Avalon-ST video pass-through with control-packet decode and frame size check.
// Build option VID_STREAM_CTRL_PARSER_DROP_ANC_EN removes ancillary packets from dout.
module vid_stream_ctrl_parser
    import vid_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned BPS        = 10,
    parameter int unsigned CPP        = 2
) (
    input  logic                  rst,
    input  logic                  is_clk,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_valid,
    input  logic                  din_sop,
    input  logic                  din_eop,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    output logic                  dout_sop,
    output logic                  dout_eop,
    input  logic                  dout_ready,
    output logic [15:0]           frame_width,
    output logic [15:0]           frame_height,
    output logic [3:0]            frame_interlace,
    output logic                  ctrl_valid,
    output logic                  frame_done,
    output logic [31:0]           pixel_count,
    output logic                  size_error
);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_CTRL  = 2'(CTRL);
    localparam logic [1:0] ST_VIDEO = 2'(VIDEO);
    localparam logic [1:0] ST_ANC   = 2'(ANC);

    if (DATA_WIDTH != BPS * CPP || CPP < 1 || CPP > 3 || BPS < 4) begin : g_bad_params
        $error("vid_stream_ctrl_parser: illegal DATA_WIDTH/BPS/CPP combination");
    end

    logic [1:0]  state;
    logic [4:0]  nib_idx;
    logic [31:0] pix_cnt;
    logic [31:0] pix_next;
    logic [31:0] frame_area;
    logic        accept;
    logic [3:0]  sop_type;
    logic        ctrl_strobe;
    logic        drop_beat;
    logic [15:0] dec_width;
    logic [15:0] dec_height;
    logic [3:0]  dec_interlace;
    logic        dec_commit;

    assign din_ready   = ~dout_valid | dout_ready;
    assign accept      = din_valid & din_ready;
    assign sop_type    = din_data[3:0];
    assign ctrl_strobe = accept & ~din_sop & (state == ST_CTRL);
    assign pix_next    = sat_inc(pix_cnt);
    assign frame_area  = 32'(frame_width) * 32'(frame_height);

`ifdef VID_STREAM_CTRL_PARSER_DROP_ANC_EN
    assign drop_beat = din_sop ? ((sop_type != PKT_VIDEO) && (sop_type != PKT_CTRL))
                               : (state == ST_ANC);
`else
    assign drop_beat = 1'b0;
`endif

    vid_stream_ctrl_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .BPS        (BPS),
        .CPP        (CPP)
    ) u_decode (
        .rst       (rst),
        .is_clk    (is_clk),
        .beat      (din_data),
        .nib_idx   (nib_idx),
        .strobe    (ctrl_strobe),
        .eop       (din_eop),
        .width     (dec_width),
        .height    (dec_height),
        .interlace (dec_interlace),
        .commit    (dec_commit)
    );

    // One-beat output register; a dropped beat simply lets dout drain
    always_ff @(posedge is_clk or posedge rst) begin
        if (rst) begin
            dout_data  <= '0;
            dout_valid <= 1'b0;
            dout_sop   <= 1'b0;
            dout_eop   <= 1'b0;
        end else if (accept && !drop_beat) begin
            dout_data  <= din_data;
            dout_valid <= 1'b1;
            dout_sop   <= din_sop;
            dout_eop   <= din_eop;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    always_ff @(posedge is_clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            nib_idx         <= '0;
            pix_cnt         <= '0;
            frame_width     <= '0;
            frame_height    <= '0;
            frame_interlace <= '0;
            ctrl_valid      <= 1'b0;
            frame_done      <= 1'b0;
            pixel_count     <= '0;
            size_error      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            size_error <= 1'b0;

            if (dec_commit) begin
                frame_width     <= dec_width;
                frame_height    <= dec_height;
                frame_interlace <= dec_interlace;
                ctrl_valid      <= 1'b1;
            end

            if (accept) begin
                if (din_sop) begin
                    // A sop always restarts decoding; an unfinished video frame is an error
                    if (state == ST_VIDEO) begin
                        size_error <= 1'b1;
                    end
                    nib_idx <= '0;
                    pix_cnt <= '0;
                    case (sop_type)
                        PKT_VIDEO: begin
                            if (din_eop) begin
                                frame_done  <= 1'b1;
                                pixel_count <= '0;
                                if (ctrl_valid && frame_area != 32'd0) begin
                                    size_error <= 1'b1;
                                end
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_VIDEO;
                            end
                        end
                        PKT_CTRL: state <= din_eop ? ST_IDLE : ST_CTRL;
                        default:  state <= din_eop ? ST_IDLE : ST_ANC;
                    endcase
                end else begin
                    case (state)
                        ST_CTRL: begin
                            if (nib_idx < 5'(CTRL_NIBBLES)) begin
                                nib_idx <= nib_idx + 5'(CPP);
                            end
                            if (din_eop) begin
                                state <= ST_IDLE;
                            end
                        end
                        ST_VIDEO: begin
                            pix_cnt <= pix_next;
                            if (din_eop) begin
                                frame_done  <= 1'b1;
                                pixel_count <= pix_next;
                                if (ctrl_valid && pix_next != frame_area) begin
                                    size_error <= 1'b1;
                                end
                                state <= ST_IDLE;
                            end
                        end
                        ST_ANC: begin
                            if (din_eop) begin
                                state <= ST_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/vid_stream_ctrl_parser.md
Name: vid_stream_ctrl_parser

Overview:
- Sits directly downstream of the clocked-video-input Avalon-ST output stage in the is_clk domain.
- Forwards every Avalon-ST video packet unchanged through a one-beat registered stage.
- Decodes control packets (type 0xF) into frame width, height and interlace flags.
- Counts pixels in each video packet (type 0) and flags size mismatches against the last decoded control packet.

Parameters:
- DATA_WIDTH, 20, beat width; must equal BPS*CPP.
- BPS, 10, bits per symbol.
- CPP, 2, symbols per beat (colour planes in parallel); legal range 1..3.

Ports:
- rst  in  1  asynchronous active-high reset
- is_clk  in  1  clock
- din_data  in  DATA_WIDTH  sink data
- din_valid  in  1  sink valid
- din_sop  in  1  sink start of packet
- din_eop  in  1  sink end of packet
- din_ready  out  1  sink ready
- dout_data  out  DATA_WIDTH  source data
- dout_valid  out  1  source valid
- dout_sop  out  1  source start of packet
- dout_eop  out  1  source end of packet
- dout_ready  in  1  source ready
- frame_width  out  16  decoded width
- frame_height  out  16  decoded height
- frame_interlace  out  4  decoded interlace nibble
- ctrl_valid  out  1  a complete control packet has been decoded since reset
- frame_done  out  1  one-cycle pulse at the eop of a video packet
- pixel_count  out  32  pixel count of the last completed video packet
- size_error  out  1  one-cycle pulse on a pixel count mismatch or a truncated video packet

Behaviour:
- Reset: rst is asynchronous and active-high; clock is is_clk. On reset:
  - all outputs go to 0, except din_ready, which follows its combinational equation (below).
  - state = IDLE and all counters = 0.
- Handshake:
  - A sink beat is accepted when din_valid & din_ready.
  - din_ready = ~dout_valid | dout_ready (combinational).
  - Each accepted beat loads dout_* on the next edge, so latency is 1 cycle.
  - dout_valid clears when a source transfer occurs with no new beat accepted.
  - dout_* hold their values while dout_valid & ~dout_ready.
- Beat fields:
  - The packet type is din_data[3:0] of the sop beat.
  - Symbol k of a beat occupies bits [BPS*k+BPS-1 : BPS*k].
  - The nibble of a symbol is its bits [3:0].
- State machine (advances only on accepted beats):
  - IDLE: on sop, type 0 -> VIDEO, type 0xF -> CTRL, any other type -> ANC. Non-sop beats are forwarded and otherwise ignored.
  - CTRL: each payload beat supplies nibbles nib_idx .. nib_idx+CPP-1 (symbol 0 first); nib_idx then advances by CPP.
    - Nibble order: 0-3 form width[15:0] MSB first; 4-7 form height[15:0]; 8 is interlace.
    - Nibbles at index 9 and above are ignored.
    - At eop: if nib_idx >= 9, commit all three fields and set ctrl_valid=1; otherwise discard the packet and leave outputs unchanged. Then -> IDLE.
  - VIDEO: each payload beat adds 1 to pix_cnt (32 bits, saturating at 0xFFFFFFFF).
    - At eop: pixel_count <= final count, frame_done pulses, and size_error pulses if ctrl_valid and the count != width*height (32-bit product). Then -> IDLE.
  - ANC: forward beats until eop, then -> IDLE.
- Sop+eop on the same beat:
  - Control packet: discarded (short).
  - Video packet: pix_cnt = 0, and the check runs against 0.
- Sop while not in IDLE (previous packet missing its eop):
  - The current packet is aborted and the new sop is decoded as in IDLE.
  - An aborted CTRL packet commits nothing.
  - An aborted VIDEO packet pulses size_error (frame_done does not pulse, pixel_count is unchanged).
- frame_done, size_error and the field commit take effect the cycle after the eop beat is accepted, i.e. in the same cycle that beat appears on dout.
- Reset during a packet drops any partial decode; the output beat is lost.

Optional Feature:
- Macro: VID_STREAM_CTRL_PARSER_DROP_ANC_EN.
- Defined:
  - Beats of ANC packets, including sop and eop, are accepted (din_ready still follows the equation) but never load dout; dout_valid stays 0 for them.
  - Control and video packets pass as normal.
- Undefined: all packets are forwarded.

Decomposition:
- Shared package vid_stream_pkg:
  - packet type constants PKT_VIDEO=4'h0 and PKT_CTRL=4'hF.
  - state enum {IDLE, CTRL, VIDEO, ANC}.
  - control nibble count constant CTRL_NIBBLES=9.
- Sub-module vid_stream_ctrl_decode: the nibble assembler, with inputs beat, nib_idx, strobe and eop; outputs width, height, interlace and commit.
- The top level keeps the FSM, the output register and the pixel counter.

Test Plan:
- CPP=2: control packet [0xF, {w3,w2}, {w1,w0}, {h3,h2}, {h1,h0}, {i,x}+eop] for 640x480 progressive -> frame_width=640, frame_height=480, frame_interlace=0, ctrl_valid=1; dout is an identical beat sequence.
- After that control packet, video packet of 307200 payload beats -> frame_done pulses once, pixel_count=307200, size_error=0; repeat with 307199 beats -> size_error pulses.
- dout_ready low for 5 cycles mid-packet -> dout beat held stable, din_ready=0, no beats lost or duplicated, pixel_count unaffected.
- Control packet with eop after 3 payload beats (6 nibbles) -> discarded; fields keep their previous 640x480 values.
- Video packet sop arriving with no eop, then a new sop -> size_error pulses, frame_done does not pulse, and the new packet decodes correctly.
- Type-0x3 ancillary packet of 4 beats with VID_STREAM_CTRL_PARSER_DROP_ANC_EN defined -> 0 dout beats and din_ready=1 throughout; with the macro undefined -> 4 dout beats.
